// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM memory port among NUM_MASTERS requesters.
// Commands pass through a one-deep register; a tag FIFO routes in-order read data back.
module mem_arbiter #(
  parameter int NUM_MASTERS = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_PENDING = 4,
  localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_rdatavalid,
  output logic                              s_read,
  output logic                              s_write,
  output logic [IDX_W+ADDR_WIDTH-1:0]       s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic                              s_waitrequest,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_rdatavalid,
  output logic                              err
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic                   cmd_valid;
  logic                   cmd_write;
  logic [IDX_W-1:0]       cmd_idx;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_wdata;
  logic [IDX_W-1:0]       rr_ptr;

  logic [IDX_W-1:0]       tag_mem [MAX_PENDING];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic                   accept;
  logic                   free;
  logic                   push;
  logic                   pop;
  logic [CNT_W:0]         pending;
  logic                   read_ok;
  logic [NUM_MASTERS-1:0] elig;
  logic                   found;
  logic [IDX_W-1:0]       win;
  logic                   grant;
  logic [IDX_W-1:0]       rr_next;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  assign accept  = cmd_valid & ~s_waitrequest;
  assign free    = ~cmd_valid | accept;
  assign push    = accept & ~cmd_write;
  assign pop     = s_rdatavalid & (count != '0);
  // A read still sitting in the command register already occupies a return slot.
  assign pending = {1'b0, count} + (CNT_W+1)'(cmd_valid & ~cmd_write);
  assign read_ok = pending < (CNT_W+1)'(MAX_PENDING);
  assign elig    = m_write | (m_read & {NUM_MASTERS{read_ok}});

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      int unsigned cand;
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && elig[IDX_W'(cand)]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end

  // Gated by rst_n so no grant leaks out combinationally while in reset.
  assign grant     = rst_n & free & found;
  assign rr_next   = (32'(win) == NUM_MASTERS - 1) ? '0 : win + 1'b1;
  assign sel_addr  = m_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = m_wdata[win*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    m_waitrequest = '1;
    if (grant) m_waitrequest[win] = 1'b0;
  end

  always_comb begin
    m_rdatavalid = '0;
    if (pop) m_rdatavalid[tag_mem[rd_ptr]] = 1'b1;
  end

  assign m_rdata = s_rdata;
  assign s_read  = cmd_valid & ~cmd_write;
  assign s_write = cmd_valid & cmd_write;
  assign s_addr  = {cmd_idx, cmd_addr};
  assign s_wdata = cmd_wdata;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= cmd_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_idx   <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (grant) begin
        cmd_valid <= 1'b1;
        cmd_write <= m_write[win];
        cmd_idx   <= win;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
        rr_ptr    <= rr_next;
      end else if (accept) begin
        cmd_valid <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (s_rdatavalid && count == '0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based round-robin reference model.
module tb_mem_arbiter;

  localparam int N  = 16;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MP = 4;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    m_read = '0;
  logic [N-1:0]    m_write = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_waitrequest;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_rdatavalid;
  logic            s_read;
  logic            s_write;
  logic [IW+AW-1:0] s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_waitrequest = 1'b0;
  logic [DW-1:0]   s_rdata = '0;
  logic            s_rdatavalid = 1'b0;
  logic            err;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int          rr;
  bit          c_v;
  bit          c_w;
  int          c_idx;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  int          tags[$];
  bit          m_err;
  bit          auto_drop;

  mem_arbiter #(
    .NUM_MASTERS(N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_PENDING(MP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_waitrequest(m_waitrequest),
    .m_rdata      (m_rdata),
    .m_rdatavalid (m_rdatavalid),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_waitrequest(s_waitrequest),
    .s_rdata      (s_rdata),
    .s_rdatavalid (s_rdatavalid),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rr = 0; c_v = 0; c_w = 0; c_idx = 0; c_addr = '0; c_data = '0;
    tags.delete(); m_err = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_s_read"},        s_read, 0);
    check({pfx, "_s_write"},       s_write, 0);
    check({pfx, "_s_addr"},        s_addr, 0);
    check({pfx, "_s_wdata"},       s_wdata, 0);
    check({pfx, "_m_waitrequest"}, m_waitrequest, {N{1'b1}});
    check({pfx, "_m_rdatavalid"},  m_rdatavalid, 0);
    check({pfx, "_err"},           err, 0);
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    int pend;
    bit free, g, acc;
    int w;
    logic [N-1:0] exp_wr, exp_rv;
    #2;
    pend = tags.size() + ((c_v && !c_w) ? 1 : 0);
    free = !c_v || !s_waitrequest;
    g = 0; w = 0;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (!g && (m_write[i] || (m_read[i] && pend < MP))) begin
          g = 1; w = i;
        end
      end
    end
    exp_wr = '1;
    if (g) exp_wr[w] = 1'b0;
    exp_rv = '0;
    if (s_rdatavalid && tags.size() > 0) exp_rv[tags[0]] = 1'b1;
    check("m_waitrequest", m_waitrequest, exp_wr);
    check("m_rdatavalid", m_rdatavalid, exp_rv);
    if (exp_rv != '0) check("m_rdata", m_rdata, s_rdata);
    check("s_read", s_read, c_v && !c_w);
    check("s_write", s_write, c_v && c_w);
    if (c_v) begin
      check("s_addr", s_addr, {IW'(c_idx), c_addr});
      check("s_wdata", s_wdata, c_data);
    end
    check("err", err, m_err);
    @(posedge clk);
    acc = c_v && !s_waitrequest;
    if (s_rdatavalid) begin
      if (tags.size() > 0) void'(tags.pop_front());
      else m_err = 1;
    end
    if (acc && !c_w) tags.push_back(c_idx);
    if (g) begin
      c_v = 1; c_w = m_write[w]; c_idx = w;
      c_addr = m_addr[w*AW +: AW];
      c_data = m_wdata[w*DW +: DW];
      rr = (w + 1) % N;
    end else if (acc) begin
      c_v = 0;
    end
    @(negedge clk);
    if (auto_drop && g) begin
      m_read[w] = 1'b0;
      m_write[w] = 1'b0;
    end
  endtask

  task automatic rand_bus();
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = AW'($urandom);
      m_wdata[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (tags.size() > 0 || c_v); k++) begin
      s_rdatavalid = tags.size() > 0;
      s_rdata = DW'($urandom);
      step();
    end
    s_rdatavalid = 1'b0;
    check("drained", tags.size(), 0);
  endtask

  initial begin
    model_reset();
    auto_drop = 0;
    rand_bus();
    m_write = '1;
    s_rdatavalid = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk); #2;
    check_reset_outputs("rst");
    @(negedge clk);
    m_write = '0; s_rdatavalid = 1'b0;
    rst_n = 1'b1;
    step();

    // Master 3: three back-to-back writes
    m_addr[3*AW +: AW] = 16'h0010;
    m_wdata[3*DW +: DW] = 16'h1234;
    m_write = N'(1) << 3;
    repeat (3) step();
    m_write = '0;
    repeat (2) step();

    // All masters writing continuously
    m_write = '1;
    repeat (18) step();
    m_write = '0;
    step();

    // Memory stall for 5 cycles with everyone requesting
    m_write = N'(1) << 1;
    step();
    s_waitrequest = 1'b1;
    m_write = '1;
    repeat (5) step();
    s_waitrequest = 1'b0;
    m_write = '0;
    repeat (2) step();

    // Reads from 2, 5, 9; data returned after a gap
    auto_drop = 1;
    m_read = (N'(1) << 2) | (N'(1) << 5) | (N'(1) << 9);
    repeat (3) step();
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      s_rdatavalid = 1'b1;
      s_rdata = DW'($urandom);
      step();
    end
    s_rdatavalid = 1'b0;
    step();

    // Pending cap: five readers, no returns
    m_read = N'(5'b11111);
    repeat (8) step();
    s_rdatavalid = 1'b1; s_rdata = 16'hBEEF;
    step();
    s_rdatavalid = 1'b0;
    repeat (2) step();
    drain();

    // Reset while a command is held with two reads outstanding
    m_read = (N'(1) << 10) | (N'(1) << 11);
    repeat (3) step();
    m_write = N'(1) << 7;
    step();
    s_waitrequest = 1'b1;
    repeat (2) step();
    #2;
    m_write = '1;
    s_rdatavalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    m_write = '0; m_read = '0; s_rdatavalid = 1'b0; s_waitrequest = 1'b0;
    rst_n = 1'b1;
    m_read = N'(1) << 6;
    repeat (3) step();
    s_rdatavalid = 1'b1; s_rdata = 16'h5A5A;
    step();
    s_rdatavalid = 1'b0;
    step();

    // Random traffic
    auto_drop = 0;
    for (int c = 0; c < 1500; c++) begin
      rand_bus();
      m_read  = N'($urandom) & N'($urandom) & N'($urandom);
      m_write = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
      s_waitrequest = ($urandom_range(0, 3) == 0);
      s_rdatavalid  = (tags.size() > 0) && ($urandom_range(0, 2) == 0);
      s_rdata = DW'($urandom);
      step();
    end
    m_read = '0; m_write = '0; s_waitrequest = 1'b0;
    drain();

    // Spurious return on an empty tag FIFO
    s_rdatavalid = 1'b1; s_rdata = 16'h0BAD;
    step();
    s_rdatavalid = 1'b0;
    repeat (3) step();
    check("err_sticky", err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single external memory port among the memory masters (delay, chorus and other application-core users). Each master gets an Avalon-MM-style read/write port; accepted commands are forwarded through a one-deep registered command stage, with the master index prepended to the address. The block tracks outstanding reads so read data is returned to the right master in order.

## Interface
Parameters:
- NUM_MASTERS, 16, number of requesters; IDX_W = $clog2(NUM_MASTERS)
- ADDR_WIDTH, 16, per-master word address width (20 - IDX_W)
- DATA_WIDTH, 16, memory word width
- MAX_PENDING, 4, maximum reads issued but not yet returned; power of two

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- m_read  in  NUM_MASTERS  per-master read request
- m_write  in  NUM_MASTERS  per-master write request
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_waitrequest  out  NUM_MASTERS  high = command not taken this cycle
- m_rdata  out  DATA_WIDTH  read data, broadcast to all masters
- m_rdatavalid  out  NUM_MASTERS  one-hot, m_rdata valid for master i
- s_read  out  1  memory read command
- s_write  out  1  memory write command
- s_addr  out  IDX_W+ADDR_WIDTH  {master index, m_addr}
- s_wdata  out  DATA_WIDTH  memory write data
- s_waitrequest  in  1  memory stall
- s_rdata  in  DATA_WIDTH  memory read data
- s_rdatavalid  in  1  memory read data valid
- err  out  1  sticky: s_rdatavalid received with no pending read

## Operation
- Request from master i: m_read[i] | m_write[i]. m_read and m_write both high = write; read dropped.
- Eligibility: writes always eligible; reads only when pending < MAX_PENDING. pending = tag FIFO count + (command register holds a read).
- Command register is free when empty, or when it holds a command accepted this cycle (s_read|s_write and !s_waitrequest).
- When free and at least one eligible request: winner = first eligible index searching upward from rr_ptr, wrapping at NUM_MASTERS-1. Load winner's command, address and data into the register. Drive m_waitrequest[winner] low this cycle; all others stay high. Set rr_ptr = winner+1 mod NUM_MASTERS.
- Command register drives s_read/s_write/s_addr/s_wdata and holds them unchanged while s_waitrequest is high.
- On read acceptance, push winner index into tag FIFO, depth MAX_PENDING.
- On s_rdatavalid: pop FIFO head h; m_rdatavalid[h]=1 combinationally in the same cycle; m_rdata = s_rdata. Push and pop in one cycle are allowed; count unchanged.
- s_rdatavalid with empty FIFO: no m_rdatavalid; err set; err cleared only by reset.
- Memory must return reads in issue order.

## Timing
- Reset values: s_read=0, s_write=0, s_addr=0, s_wdata=0, m_waitrequest all 1, m_rdatavalid all 0, err=0, rr_ptr=0, FIFO empty.
- Grant latency: request seen at cycle t with register free -> m_waitrequest[i]=0 at t; s_read/s_write high from t+1.
- Throughput: one command per cycle while s_waitrequest stays low.
- Read return: 0 cycles from s_rdatavalid to m_rdatavalid.
- Pending cap: with MAX_PENDING reads pending, no read is granted until a pop frees a slot. Pop at cycle t allows a read grant at t+1.
- Asynchronous reset mid-transfer: command dropped, tags discarded, all outputs to reset values immediately.

## Test plan
- Single master 3 writes addr 0x0010, data 0x1234: s_write for 3 consecutive cycles, s_addr={3,0x0010}, m_waitrequest[3] low once per command.
- All 16 masters continuously requesting writes: grants 0,1,...,15,0 with no master granted twice within any 16 consecutive grants.
- s_waitrequest held high 5 cycles on a command: s_* stable 5 cycles; no new grant; m_waitrequest all high.
- Masters 2,5,9 each read once; memory returns 3 words after 4 cycles: m_rdatavalid one-hot 2,5,9 in order with matching data.
- MAX_PENDING=4 and 5 reads with no return: 4 issued, 5th waits; first s_rdatavalid pop -> 5th issued next cycle. Spurious s_rdatavalid on empty FIFO -> err=1 and stays 1.
- rst_n low during held command with 2 pending: outputs at reset values asynchronously; a new read after reset is routed correctly.
